// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Wait-state counter width; holds WAIT_CYCLES-1 for WAIT_CYCLES up to 15.
  localparam int CNT_W = 4;

  // Response error flag values.
  localparam logic ERR_NONE   = 1'b0;
  localparam logic ERR_ACCESS = 1'b1;

  // An access faults when it is not word aligned or its word index lies past the array.
  function automatic logic access_err(input logic [31:0] addr, input logic [31:0] depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write port, combinational read port.
module dmem_array #(
  parameter  int DEPTH_WORDS = 256,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] widx,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] ridx,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Write the addressed word on the clock edge when enabled.
  // NOTE: the array has no reset; clearing every word would cost a write port per
  // entry and the contents are defined as undefined until written anyway.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time, programmable wait
// states, single-cycle response strobe; busy stalls the pipeline while in flight.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter  int DEPTH_WORDS = 256,
  parameter  int WAIT_CYCLES = 2,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic          accept;
  logic          commit;
  logic          c_write;
  logic [31:0]   c_addr;
  logic [31:0]   c_wdata;
  logic          c_err;
  logic          mem_we;
  logic [AW-1:0] mem_idx;
  logic [31:0]   mem_rdata;

  assign req_ready = (state == IDLE);
  assign busy      = !req_ready;
  assign rsp_valid = (state == RESP);
  assign accept    = req_ready && req_valid;

  // Next-state and wait-counter logic.
  // NOTE: every output of this block is defaulted first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_W'(WAIT_CYCLES - 1);
          end else begin
            state_nxt = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and counter registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Capture the request fields on the accept edge; they need not stay stable after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_write <= req_write;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

  // The commit happens on the edge entering RESP. With zero wait states that is the
  // accept edge itself, so the live request fields are used instead of the latched ones.
  assign commit  = (state_nxt == RESP) && (state != RESP);
  assign c_write = (state == IDLE) ? req_write : lat_write;
  assign c_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign c_wdata = (state == IDLE) ? req_wdata : lat_wdata;
  assign c_err   = access_err(c_addr, 32'(DEPTH_WORDS));

  assign mem_we  = commit && c_write && !c_err;
  assign mem_idx = c_addr[AW+1:2];

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .widx (mem_idx),
    .wdata(c_wdata),
    .ridx (mem_idx),
    .rdata(mem_rdata)
  );

  // Response registers: loaded at commit, cleared when leaving RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_err   <= ERR_NONE;
    end else if (commit) begin
      rsp_err   <= c_err ? ERR_ACCESS : ERR_NONE;
      rsp_rdata <= (!c_write && !c_err) ? mem_rdata : '0;
    end else if (state == RESP) begin
      rsp_rdata <= '0;
      rsp_err   <= ERR_NONE;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (2, 0 and 3 wait states) driven by
// directed requests, checked every cycle against a timing/memory model.
module tb_dmem_responder;

  localparam int N_DUT = 3;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [N_DUT];
  logic        req_write [N_DUT];
  logic [31:0] req_addr  [N_DUT];
  logic [31:0] req_wdata [N_DUT];
  logic        req_ready [N_DUT];
  logic        rsp_valid [N_DUT];
  logic [31:0] rsp_rdata [N_DUT];
  logic        rsp_err   [N_DUT];
  logic        busy      [N_DUT];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic int wc(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 0 : 3);
  endfunction

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS(DEPTH),
      .WAIT_CYCLES((g == 0) ? 2 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid[g]),
      .req_write(req_write[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .req_ready(req_ready[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g]),
      .busy     (busy[g])
    );
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Pure timing arithmetic: a request accepted at cycle index A keeps the unit busy
  // for cycles A..A+W and responds in cycle A+W; the memory effect lands at the edge
  // that starts cycle A+W.
  int          cyc = 0;
  bit          pend    [N_DUT];
  int          acc     [N_DUT];
  bit          m_wr    [N_DUT];
  logic [31:0] m_addr  [N_DUT];
  logic [31:0] m_wdata [N_DUT];
  logic [31:0] mmem    [N_DUT][DEPTH];
  bit          mknown  [N_DUT][DEPTH];
  logic [31:0] e_rdata [N_DUT];
  bit          e_err   [N_DUT];
  bit          e_known [N_DUT];
  bit          prev_rv [N_DUT];

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst_n === 1'b1) begin
      for (int i = 0; i < N_DUT; i++) begin
        if ((!pend[i] || cyc > acc[i] + wc(i) + 1) && req_valid[i] === 1'b1) begin
          pend[i]    = 1'b1;
          acc[i]     = cyc;
          m_wr[i]    = req_write[i];
          m_addr[i]  = req_addr[i];
          m_wdata[i] = req_wdata[i];
        end
        if (pend[i] && cyc == acc[i] + wc(i)) begin
          e_err[i] = (m_addr[i] % 4 != 0) || (m_addr[i] / 4 >= DEPTH);
          e_rdata[i] = 32'h0;
          e_known[i] = 1'b1;
          if (!e_err[i]) begin
            if (m_wr[i]) begin
              mmem[i][m_addr[i] / 4]   = m_wdata[i];
              mknown[i][m_addr[i] / 4] = 1'b1;
            end else begin
              e_rdata[i] = mmem[i][m_addr[i] / 4];
              e_known[i] = mknown[i][m_addr[i] / 4];
            end
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge rst_n);
    for (int i = 0; i < N_DUT; i++) pend[i] = 1'b0;
  end

  // Compare every instance on every falling edge while out of reset.
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      for (int i = 0; i < N_DUT; i++) begin
        bit b, rv;
        b  = pend[i] && cyc >= acc[i] && cyc <= acc[i] + wc(i);
        rv = pend[i] && cyc == acc[i] + wc(i);
        check($sformatf("u%0d.busy", i), 32'(busy[i]), 32'(b));
        check($sformatf("u%0d.req_ready", i), 32'(req_ready[i]), 32'(!b));
        check($sformatf("u%0d.rsp_valid", i), 32'(rsp_valid[i]), 32'(rv));
        check($sformatf("u%0d.rsp_err", i), 32'(rsp_err[i]), 32'(rv && e_err[i]));
        if (!rv || e_known[i])
          check($sformatf("u%0d.rsp_rdata", i), rsp_rdata[i], rv ? e_rdata[i] : 32'h0);
        check($sformatf("u%0d.rsp_valid_twice", i), 32'(prev_rv[i] && rsp_valid[i]), 32'h0);
        prev_rv[i] = rsp_valid[i];
      end
    end else begin
      for (int i = 0; i < N_DUT; i++) prev_rv[i] = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Hold until req_ready is seen high in a low clock phase, then step past the accept edge.
  task automatic wait_accept(input int i, output int steps);
    bit ok;
    ok    = 1'b0;
    steps = 0;
    for (int k = 0; k < 50; k++) begin
      if (req_ready[i] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      steps++;
    end
    if (!ok) fail_now($sformatf("u%0d.accept_timeout", i));
    @(posedge clk);
    #1;
  endtask

  // Count falling edges from the accept edge to the response strobe.
  task automatic wait_rsp(input int i, output logic [31:0] rd, output logic er, output int lat);
    lat = -1;
    rd  = 'x;
    er  = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rsp_valid[i] === 1'b1) begin
        lat = k;
        rd  = rsp_rdata[i];
        er  = rsp_err[i];
        break;
      end
    end
    if (lat < 0) fail_now($sformatf("u%0d.rsp_timeout", i));
  endtask

  task automatic do_req(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
    int steps;
    req_write[i] = wr;
    req_addr[i]  = a;
    req_wdata[i] = d;
    req_valid[i] = 1'b1;
    wait_accept(i, steps);
    req_valid[i] = 1'b0;
    req_write[i] = 1'($urandom);
    req_addr[i]  = $urandom;
    req_wdata[i] = $urandom;
    wait_rsp(i, rd, er, lat);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          steps;

    rst_n = 1'b0;
    for (int i = 0; i < N_DUT; i++) begin
      req_valid[i] = 1'b0;
      req_write[i] = 1'b0;
      req_addr[i]  = '0;
      req_wdata[i] = '0;
    end
    #1;
    for (int i = 0; i < N_DUT; i++) begin
      check($sformatf("u%0d.reset_ready", i), 32'(req_ready[i]), 32'h1);
      check($sformatf("u%0d.reset_busy", i), 32'(busy[i]), 32'h0);
      check($sformatf("u%0d.reset_rsp_valid", i), 32'(rsp_valid[i]), 32'h0);
      check($sformatf("u%0d.reset_rdata", i), rsp_rdata[i], 32'h0);
      check($sformatf("u%0d.reset_err", i), 32'(rsp_err[i]), 32'h0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Two wait states: store then load of 0x10.
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    check("w2_store_latency", 32'(lat), 32'd3);
    check("w2_store_err", 32'(er), 32'h0);
    check("w2_store_rdata", rd, 32'h0);
    do_req(0, 1'b0, 32'h10, 32'h0, rd, er, lat);
    check("w2_load_latency", 32'(lat), 32'd3);
    check("w2_load_rdata", rd, 32'hDEADBEEF);

    // Error cases leave word 0 untouched.
    do_req(0, 1'b1, 32'h0, 32'hCAFEF00D, rd, er, lat);
    do_req(0, 1'b0, 32'h6, 32'h0, rd, er, lat);
    check("misaligned_err", 32'(er), 32'h1);
    check("misaligned_rdata", rd, 32'h0);
    do_req(0, 1'b1, 32'h400, 32'hBAD0BAD0, rd, er, lat);
    check("range_store_err", 32'(er), 32'h1);
    do_req(0, 1'b1, 32'h8000_0000, 32'hBAD1BAD1, rd, er, lat);
    check("high_addr_err", 32'(er), 32'h1);
    do_req(0, 1'b0, 32'h0, 32'h0, rd, er, lat);
    check("word0_unchanged", rd, 32'hCAFEF00D);
    check("word0_err", 32'(er), 32'h0);
    do_req(0, 1'b1, 32'h3FC, 32'h5A5A0001, rd, er, lat);
    check("last_word_store_err", 32'(er), 32'h0);
    do_req(0, 1'b0, 32'h3FC, 32'h0, rd, er, lat);
    check("last_word_load", rd, 32'h5A5A0001);

    // Reset in the middle of a store's wait states.
    do_req(0, 1'b1, 32'h20, 32'h11111111, rd, er, lat);
    req_write[0] = 1'b1;
    req_addr[0]  = 32'h20;
    req_wdata[0] = 32'hA5A5A5A5;
    req_valid[0] = 1'b1;
    wait_accept(0, steps);
    req_valid[0] = 1'b0;
    #2;
    check("pre_reset_busy", 32'(busy[0]), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_ready", 32'(req_ready[0]), 32'h1);
    check("mid_reset_busy", 32'(busy[0]), 32'h0);
    check("mid_reset_rsp_valid", 32'(rsp_valid[0]), 32'h0);
    check("mid_reset_rdata", rsp_rdata[0], 32'h0);
    check("mid_reset_err", 32'(rsp_err[0]), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_reset_no_rsp", 32'(rsp_valid[0]), 32'h0);
    end
    do_req(0, 1'b0, 32'h20, 32'h0, rd, er, lat);
    check("aborted_store_not_committed", rd, 32'h11111111);

    // Zero wait states: back-to-back store and load.
    check("w0_ready_before", 32'(req_ready[1]), 32'h1);
    do_req(1, 1'b1, 32'h4, 32'h1234, rd, er, lat);
    check("w0_store_latency", 32'(lat), 32'd1);
    check("w0_ready_in_resp", 32'(req_ready[1]), 32'h0);
    @(negedge clk);
    check("w0_ready_after", 32'(req_ready[1]), 32'h1);
    do_req(1, 1'b0, 32'h4, 32'h0, rd, er, lat);
    check("w0_load_latency", 32'(lat), 32'd1);
    check("w0_load_rdata", rd, 32'h00001234);

    // Three wait states, req_valid held high while the address changes.
    do_req(2, 1'b1, 32'h40, 32'h40404040, rd, er, lat);
    do_req(2, 1'b1, 32'h44, 32'h44444444, rd, er, lat);
    req_write[2] = 1'b0;
    req_addr[2]  = 32'h40;
    req_valid[2] = 1'b1;
    wait_accept(2, steps);
    req_addr[2] = 32'h44;
    wait_rsp(2, rd, er, lat);
    check("held_first_latency", 32'(lat), 32'd4);
    check("held_first_rdata", rd, 32'h40404040);
    wait_accept(2, steps);
    req_valid[2] = 1'b0;
    check("held_second_gap", 32'(steps), 32'd1);
    wait_rsp(2, rd, er, lat);
    check("held_second_latency", 32'(lat), 32'd4);
    check("held_second_rdata", rd, 32'h44444444);

    repeat (6) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
